// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch
// Description : Single-outstanding-request instruction fetch stage with
//               redirect (flush) handling, decode back-pressure and a sticky
//               memory-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch #(
    parameter int n   = 32,
    parameter int TMO = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [n-1:0] pc,
    input  logic         flush,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         dec_ready,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    output logic [31:0]  instr,
    output logic [n-1:0] instr_pc,
    output logic         instr_valid,
    output logic         pc_advance,
    output logic         fetch_err
);

    localparam int             c_CW  = (TMO < 1) ? 1 : $clog2(TMO + 1);
    localparam logic [c_CW-1:0] c_TMO = c_CW'(TMO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;

    // Wait counter saturates so a hung memory cannot wrap it back below TMO.
    assign w_cnt_nxt = (r_cnt == c_TMO) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pc_advance  <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            pc_advance <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!flush) begin
                        r_state   <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        r_cnt     <= '0;
                    end
                end

                REQ: begin
                    if (flush) begin
                        if (imem_ack) begin
                            r_state  <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            // Request already issued: keep it up until memory answers.
                            r_state <= DRAIN;
                            r_cnt   <= '0;
                        end
                    end else if (imem_ack) begin
                        r_state     <= HOLD;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        pc_advance  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == c_TMO) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (flush) begin
                        r_state     <= IDLE;
                        instr_valid <= 1'b0;
                    end else if (dec_ready) begin
                        r_state     <= REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                        r_cnt       <= '0;
                    end
                end

                DRAIN: begin
                    if (imem_ack) begin
                        r_state  <= IDLE;
                        imem_req <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == c_TMO) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
